// File: rtl/counter_if.sv
// rtl/counter_if.sv - count bus shared between the counter and its observers
interface counter_if #(
    parameter int N = 4
);
    logic [N-1:0] count;

    modport master (output count);
    modport slave  (input  count);
endinterface

// File: rtl/counter.sv
// rtl/counter.sv - free-running N-bit up counter with synchronous active-high clear
module counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] count
);

    // Count register: clear wins over increment; the MSB carry falls off so the value wraps to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + N'(1);
        end
    end

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter at N=1, N=4 and N=8
module tb_counter;

    typedef struct {
        int         idx;
        logic [3:0] e4;
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    bit   clk;
    logic reset;

    counter_if #(.N(4)) if4 ();
    counter_if #(.N(1)) if1 ();
    counter_if #(.N(8)) if8 ();

    counter #(.N(4)) u4 (.clk(clk), .reset(reset), .count(if4.count));
    counter #(.N(1)) u1 (.clk(clk), .reset(reset), .count(if1.count));
    counter #(.N(8)) u8 (.clk(clk), .reset(reset), .count(if8.count));

    always #5 clk = ~clk;

    exp_t q[$];
    bit   v_rst[$];
    bit   v_glitch[$];
    int   v_exp[$];

    int checks = 0;
    int errors = 0;

    task automatic add(input bit r, input bit g, input int e);
        v_rst.push_back(r);
        v_glitch.push_back(g);
        v_exp.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Monitor: shortly after every rising edge, pop the oldest expectation and compare all three counters.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count_n4", e.idx, int'(if4.count), int'(e.e4));
                check("count_n1", e.idx, int'(if1.count), int'(e.e1));
                check("count_n8", e.idx, int'(if8.count), int'(e.e8));
            end
        end
    end

    // Driver: apply each vector before its edge and queue the expected post-edge values.
    initial begin
        int   k;
        exp_t e;

        // Power-up: reset from t=0, count 0 after t=5, then 1..6
        add(1, 0, 0);
        for (int i = 1; i <= 6; i++) add(0, 0, i);
        // Reset mid-operation at count 6, then 1..10 (10 after t=175)
        add(1, 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 0, i);
        // Run up to the wrap value, then reset on the wrap edge
        for (int i = 11; i <= 15; i++) add(0, 0, i);
        add(1, 0, 0);
        // Full wrap: 1..15 then 0, then 1; some cycles carry a reset glitch between edges
        for (int i = 1; i <= 15; i++) add(0, (i % 4 == 2), i);
        add(0, 1, 0);
        add(0, 0, 1);
        // Held reset for 5 edges, then release
        for (int i = 0; i < 5; i++) add(1, 0, 0);
        add(0, 0, 1);
        add(0, 1, 2);
        add(0, 0, 3);
        // Long run so the 8-bit counter passes 255 -> 0
        for (int i = 4; i < 4 + 260; i++) add(0, 0, i % 16);
        // Reset from a non-zero 8-bit value, then resume
        add(1, 0, 0);
        add(0, 0, 1);

        k = 0;
        for (int i = 0; i < v_rst.size(); i++) begin
            reset = v_rst[i];
            if (v_rst[i]) k = 0;
            else          k = k + 1;
            e.idx = i;
            e.e4  = 4'(v_exp[i]);
            e.e1  = 1'(k % 2);
            e.e8  = 8'(k % 256);
            q.push_back(e);
            if (v_glitch[i]) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
            @(negedge clk);
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
